banco_reg_sb: RTL and testbench
===============================

Name: banco_reg_sb

Overview:
Parametrised register file for the pipelined core with NR combinational read ports and one write port. Register 0 is hardwired to zero. Same-cycle write-to-read bypass is selectable by parameter. An integrated busy scoreboard tracks in-flight destination registers and flags read hazards to the issue stage. It sits between decode/issue (read and issue side) and writeback (write side).

Parameters:
ANCHO, 32, data width in bits
N, 5, address width; 2**N registers
NR, 2, number of read ports (1..4)
BYPASS, 1, 1 = the writeback value is forwarded to reads in the same cycle; 0 = reads return stored contents only

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
we  input  1  writeback enable
addr_rd  input  N  writeback address
data_in  input  ANCHO  writeback data
addr_rs  input  NR*N  read addresses; port k at [k*N +: N]
rs  output  NR*ANCHO  read data; port k at [k*ANCHO +: ANCHO]
iss_en  input  1  an instruction issues this cycle with destination iss_rd
iss_rd  input  N  destination of the issuing instruction
flush  input  1  synchronous clear of all busy bits
hazard  output  NR  port k source is pending, not resolved by bypass
busy_vec  output  2**N  registered busy bit per register
pend_cnt  output  N+1  registered count of set busy bits

Behaviour:
- Reset (async, rst=1): all registers clear to 0, busy_vec=0, pend_cnt=0. rs and hazard then follow the combinational rules below (all zero unless a bypass is active). Reset asserted mid-operation discards all pending state immediately.
- Write: at clk edge, if we && addr_rd!=0, reg[addr_rd] <= data_in. Writes to register 0 are ignored.
- Read (combinational, per port k):
  - addr_rs[k]==0 -> rs[k]=0.
  - Else if BYPASS && we && addr_rd==addr_rs[k] -> rs[k]=data_in.
  - Else rs[k]=reg[addr_rs[k]].
- Scoreboard next-state for bit r (r!=0), priority order:
  - flush -> 0. Flush overrides issue and writeback in the same cycle.
  - iss_en && iss_rd==r -> 1. Issue wins over a same-cycle writeback to the same register.
  - we && addr_rd==r -> 0.
  - Otherwise hold.
  - Bit 0 is always 0. An issue to register 0 is ignored.
- Counter: pend_cnt is updated incrementally, not by popcount.
  - +1 when a clear bit becomes set.
  - -1 when a set bit becomes clear.
  - Both can happen in one cycle (issue to r1, writeback to r2) -> net 0.
  - flush -> 0.
  - Invariant: pend_cnt == popcount(busy_vec) at every cycle. No overflow is possible, since the maximum is 2**N-1.
- Hazard (combinational, per port k):
  - Base condition: busy_vec[addr_rs[k]].
  - With BYPASS=1, masked when we && addr_rd==addr_rs[k].
  - With BYPASS=0, not masked; the consumer retries next cycle.
  - A same-cycle iss_en does not affect hazard; the new busy bit takes effect from the next cycle.
- Writeback to a register that is not busy is legal: the data is written and the scoreboard is unchanged.
- Latency:
  - Write visible to reads from the next cycle, or the same cycle when BYPASS=1.
  - Busy set and clear visible from the next cycle.

Decomposition:
- Shared constants header holds REG_ZERO (address 0) and the default ANCHO/N. The core's decode stage uses the same values.
- One natural sub-module, marcador_ocup. It holds busy_vec, pend_cnt and the set/clear/flush priority logic, parameterised by N.
- The data array, read muxing and bypass stay in banco_reg_sb. The array reuses the existing enable-register primitive per entry.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 and 0x12345678 to r0; read r5/r0 next cycle -> rs0=0xDEADBEEF, rs1=0; write to r0 discarded.
- BYPASS=1: we=1, addr_rd=7, data_in=0xA5A5A5A5, addr_rs0=7 in the same cycle -> rs0=0xA5A5A5A5; with BYPASS=0 -> old value (0).
- Issue r3, next cycle read r3 -> hazard[0]=1, busy_vec[3]=1, pend_cnt=1. Writeback r3 with BYPASS=1 -> hazard[0]=0 that cycle; next cycle busy_vec[3]=0, pend_cnt=0.
- Same cycle: issue r4 and writeback r4 while r4 busy -> r4 stays busy, pend_cnt unchanged. Issue r9 + writeback r4 -> pend_cnt unchanged, bits swap.
- Issue r1..r6 over six cycles (pend_cnt=6), then flush together with iss_en to r8 -> busy_vec=0, pend_cnt=0. Issue r0 -> no change.
- Assert rst asynchronously between edges with pend_cnt=3 and data stored -> busy_vec, pend_cnt and all registers 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/banco_reg_sb_pkg.sv
// Constants shared by the register file, its scoreboard and the decode stage.
package banco_reg_sb_pkg;

  localparam int unsigned ANCHO_DEF = 32;
  localparam int unsigned N_DEF     = 5;
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/banco_reg_sb_marcador_ocup.sv
// Busy scoreboard: one bit per destination register plus a running count of
// set bits, maintained incrementally so it never needs a popcount tree.
module marcador_ocup
  import banco_reg_sb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_en,
  input  logic [N-1:0]    iss_rd,
  input  logic            we,
  input  logic [N-1:0]    addr_rd,
  input  logic            flush,
  output logic [2**N-1:0] busy_vec,
  output logic [N:0]      pend_cnt
);

  localparam int NREG = 2**N;

  logic [NREG-1:0] busy_d, busy_q;
  logic [N:0]      cnt_d, cnt_q;
  logic            iss_ok, wb_ok, set_new, clr_old;

  always_comb begin
    iss_ok  = iss_en && (iss_rd != N'(REG_ZERO));
    wb_ok   = we && (addr_rd != N'(REG_ZERO));
    set_new = iss_ok && !busy_q[iss_rd];
    // A writeback colliding with a same-cycle issue leaves the bit set.
    clr_old = wb_ok && busy_q[addr_rd] && !(iss_ok && (iss_rd == addr_rd));
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wb_ok)  busy_d[addr_rd] = 1'b0;
      if (iss_ok) busy_d[iss_rd]  = 1'b1;
      cnt_d = cnt_q + (N+1)'(set_new) - (N+1)'(clr_old);
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/banco_reg_sb.sv
// Register file with NR combinational read ports, one write port, optional
// same-cycle write-to-read bypass and an integrated busy scoreboard.
module banco_reg_sb
  import banco_reg_sb_pkg::*;
#(
  parameter int ANCHO  = ANCHO_DEF,
  parameter int N      = N_DEF,
  parameter int NR     = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [N-1:0]        addr_rd,
  input  logic [ANCHO-1:0]    data_in,
  input  logic [NR*N-1:0]     addr_rs,
  output logic [NR*ANCHO-1:0] rs,
  input  logic                iss_en,
  input  logic [N-1:0]        iss_rd,
  input  logic                flush,
  output logic [NR-1:0]       hazard,
  output logic [2**N-1:0]     busy_vec,
  output logic [N:0]          pend_cnt
);

  localparam int NREG = 2**N;

  logic [ANCHO-1:0] mem_d [NREG];
  logic [ANCHO-1:0] mem_q [NREG];
  logic             wr_en;

  assign wr_en = we && (addr_rd != N'(REG_ZERO));

  // Each entry behaves as an enable register selected by the write address.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = (wr_en && (addr_rd == N'(i))) ? data_in : mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
      logic [N-1:0]     a_sel;
      logic             byp;
      logic [ANCHO-1:0] rd_val;

      assign a_sel = addr_rs[gi*N +: N];

      always_comb begin
        byp = (BYPASS != 0) && we && (addr_rd == a_sel);
        if (a_sel == N'(REG_ZERO)) rd_val = '0;
        else if (byp)              rd_val = data_in;
        else                       rd_val = mem_q[a_sel];
        // Without bypass the consumer simply retries on the next cycle.
        hazard[gi] = busy_vec[a_sel] && !byp;
      end

      assign rs[gi*ANCHO +: ANCHO] = rd_val;
    end
  endgenerate

  marcador_ocup #(.N(N)) u_marcador (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .we       (we),
    .addr_rd  (addr_rd),
    .flush    (flush),
    .busy_vec (busy_vec),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_banco_reg_sb.sv
// Bench for banco_reg_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus and
// are checked against an array/bit-set model of the register file.
module tb_banco_reg_sb;

  localparam int ANCHO = 32;
  localparam int N     = 5;
  localparam int NR    = 2;
  localparam int NREG  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [N-1:0]    addr_rd;
  logic [ANCHO-1:0] data_in;
  logic [NR*N-1:0] addr_rs;
  logic            iss_en;
  logic [N-1:0]    iss_rd;
  logic            flush;

  logic [NR*ANCHO-1:0] rs_b1, rs_b0;
  logic [NR-1:0]       hz_b1, hz_b0;
  logic [NREG-1:0]     bv_b1, bv_b0;
  logic [N:0]          pc_b1, pc_b0;

  int checks   = 0;
  int failures = 0;

  logic [ANCHO-1:0] m_regs [NREG];
  bit               m_busy [NREG];

  always #5 clk = ~clk;

  banco_reg_sb #(.ANCHO(ANCHO), .N(N), .NR(NR), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .we(we), .addr_rd(addr_rd), .data_in(data_in),
    .addr_rs(addr_rs), .rs(rs_b1), .iss_en(iss_en), .iss_rd(iss_rd),
    .flush(flush), .hazard(hz_b1), .busy_vec(bv_b1), .pend_cnt(pc_b1)
  );

  banco_reg_sb #(.ANCHO(ANCHO), .N(N), .NR(NR), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .we(we), .addr_rd(addr_rd), .data_in(data_in),
    .addr_rs(addr_rs), .rs(rs_b0), .iss_en(iss_en), .iss_rd(iss_rd),
    .flush(flush), .hazard(hz_b0), .busy_vec(bv_b0), .pend_cnt(pc_b0)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (we && addr_rd != 0) m_regs[addr_rd] = data_in;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (we && addr_rd != 0) m_busy[addr_rd] = 1'b0;
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  function automatic logic [ANCHO-1:0] exp_rs(int a, bit byp);
    if (a == 0) return '0;
    if (byp && we && addr_rd == N'(a)) return data_in;
    return m_regs[a];
  endfunction

  function automatic bit exp_hz(int a, bit byp);
    if (byp && we && addr_rd == N'(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NREG-1:0] exp_bv();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += m_busy[i];
    return c;
  endfunction

  task automatic idle();
    we = 1'b0; addr_rd = '0; data_in = '0; addr_rs = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #3;
    checks++;
    if (bv_b1 !== '0 || bv_b0 !== '0) begin
      failures++; $display("FAIL reset_busy got=%h/%h exp=0", bv_b1, bv_b0);
    end
    checks++;
    if (pc_b1 !== '0 || pc_b0 !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0", pc_b1, pc_b0);
    end
    checks++;
    if (rs_b1 !== '0 || rs_b0 !== '0 || hz_b1 !== '0 || hz_b0 !== '0) begin
      failures++; $display("FAIL reset_rs got=%h/%h hz=%b/%b exp=0", rs_b1, rs_b0, hz_b1, hz_b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    we = 1'b1; addr_rd = 5'd5; data_in = 32'hDEADBEEF;
    tick();
    addr_rd = 5'd0; data_in = 32'h12345678;
    tick();
    idle();
    addr_rs = {5'd0, 5'd5};
    #2;
    checks++;
    if (rs_b1[31:0] !== 32'hDEADBEEF || rs_b0[31:0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_r5 got=%h/%h exp=deadbeef", rs_b1[31:0], rs_b0[31:0]);
    end
    checks++;
    if (rs_b1[63:32] !== '0 || rs_b0[63:32] !== '0) begin
      failures++; $display("FAIL wr_r0 got=%h/%h exp=0", rs_b1[63:32], rs_b0[63:32]);
    end
    $display("test_write_read done");
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; addr_rd = 5'd7; data_in = 32'hA5A5A5A5;
    addr_rs = {5'd5, 5'd7};
    #2;
    checks++;
    if (rs_b1[31:0] !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL byp1_same got=%h exp=a5a5a5a5", rs_b1[31:0]);
    end
    checks++;
    if (rs_b0[31:0] !== 32'h0) begin
      failures++; $display("FAIL byp0_same got=%h exp=0", rs_b0[31:0]);
    end
    tick();
    we = 1'b0;
    #2;
    checks++;
    if (rs_b1[31:0] !== 32'hA5A5A5A5 || rs_b0[31:0] !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL byp_next got=%h/%h exp=a5a5a5a5", rs_b1[31:0], rs_b0[31:0]);
    end
    $display("test_bypass done");
  endtask

  task automatic test_hazard();
    idle();
    iss_en = 1'b1; iss_rd = 5'd3; addr_rs = {5'd0, 5'd3};
    #2;
    checks++;
    if (hz_b1[0] !== 1'b0) begin
      failures++; $display("FAIL hz_issue_same got=%b exp=0", hz_b1[0]);
    end
    tick();
    iss_en = 1'b0;
    #2;
    checks++;
    if (hz_b1[0] !== 1'b1 || hz_b0[0] !== 1'b1 || bv_b1[3] !== 1'b1 || pc_b1 !== 6'd1) begin
      failures++; $display("FAIL hz_busy got=hz%b/%b bv3=%b cnt=%0d exp=hz1/1 bv3=1 cnt=1",
                           hz_b1[0], hz_b0[0], bv_b1[3], pc_b1);
    end
    we = 1'b1; addr_rd = 5'd3; data_in = 32'h00C0FFEE;
    #2;
    checks++;
    if (hz_b1[0] !== 1'b0 || hz_b0[0] !== 1'b1) begin
      failures++; $display("FAIL hz_wb_mask got=%b/%b exp=0/1", hz_b1[0], hz_b0[0]);
    end
    tick();
    we = 1'b0;
    #2;
    checks++;
    if (bv_b1[3] !== 1'b0 || pc_b1 !== 6'd0 || hz_b0[0] !== 1'b0) begin
      failures++; $display("FAIL hz_cleared got=bv3=%b cnt=%0d hz0=%b exp=0/0/0", bv_b1[3], pc_b1, hz_b0[0]);
    end
    $display("test_hazard done");
  endtask

  task automatic test_same_cycle();
    idle();
    iss_en = 1'b1; iss_rd = 5'd4;
    tick();
    we = 1'b1; addr_rd = 5'd4; data_in = 32'h44;
    tick();
    idle();
    #2;
    checks++;
    if (bv_b1[4] !== 1'b1 || pc_b1 !== 6'd1) begin
      failures++; $display("FAIL same_r4 got=bv4=%b cnt=%0d exp=1/1", bv_b1[4], pc_b1);
    end
    iss_en = 1'b1; iss_rd = 5'd9; we = 1'b1; addr_rd = 5'd4; data_in = 32'h4444;
    tick();
    idle();
    #2;
    checks++;
    if (bv_b1[4] !== 1'b0 || bv_b1[9] !== 1'b1 || pc_b1 !== 6'd1 || pc_b0 !== 6'd1) begin
      failures++; $display("FAIL swap got=bv4=%b bv9=%b cnt=%0d/%0d exp=0/1/1/1", bv_b1[4], bv_b1[9], pc_b1, pc_b0);
    end
    we = 1'b1; addr_rd = 5'd9; data_in = 32'h99;
    tick();
    idle();
    $display("test_same_cycle done");
  endtask

  task automatic test_flush();
    idle();
    for (int i = 1; i <= 6; i++) begin
      iss_en = 1'b1; iss_rd = N'(i);
      tick();
    end
    iss_en = 1'b0;
    #2;
    checks++;
    if (pc_b1 !== 6'd6 || bv_b1 !== 32'h0000007E) begin
      failures++; $display("FAIL flush_pre got=cnt=%0d bv=%h exp=6/0000007e", pc_b1, bv_b1);
    end
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd8;
    tick();
    idle();
    #2;
    checks++;
    if (pc_b1 !== '0 || bv_b1 !== '0 || pc_b0 !== '0 || bv_b0 !== '0) begin
      failures++; $display("FAIL flush got=cnt=%0d bv=%h exp=0/0", pc_b1, bv_b1);
    end
    iss_en = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    #2;
    checks++;
    if (pc_b1 !== '0 || bv_b1 !== '0) begin
      failures++; $display("FAIL issue_r0 got=cnt=%0d bv=%h exp=0/0", pc_b1, bv_b1);
    end
    $display("test_flush done");
  endtask

  task automatic test_random();
    int a;
    for (int cyc = 0; cyc < 400; cyc++) begin
      we      = ($urandom_range(0, 2) != 0);
      addr_rd = N'($urandom_range(0, 7));
      data_in = $urandom;
      addr_rs = {N'($urandom_range(0, 7)), N'($urandom_range(0, 7))};
      iss_en  = ($urandom_range(0, 1) != 0);
      iss_rd  = N'($urandom_range(0, 7));
      flush   = ($urandom_range(0, 15) == 0);
      if (cyc % 50 == 0) begin
        addr_rd = N'($urandom_range(0, NREG - 1));
        iss_rd  = N'($urandom_range(0, NREG - 1));
      end
      #2;
      for (int k = 0; k < NR; k++) begin
        a = int'(addr_rs[k*N +: N]);
        checks++;
        if (rs_b1[k*ANCHO +: ANCHO] !== exp_rs(a, 1'b1) || rs_b0[k*ANCHO +: ANCHO] !== exp_rs(a, 1'b0)) begin
          failures++;
          $display("FAIL rnd_rs cyc=%0d port=%0d got=%h/%h exp=%h/%h", cyc, k,
                   rs_b1[k*ANCHO +: ANCHO], rs_b0[k*ANCHO +: ANCHO], exp_rs(a, 1'b1), exp_rs(a, 1'b0));
        end
        checks++;
        if (hz_b1[k] !== exp_hz(a, 1'b1) || hz_b0[k] !== exp_hz(a, 1'b0)) begin
          failures++;
          $display("FAIL rnd_hz cyc=%0d port=%0d got=%b/%b exp=%b/%b", cyc, k,
                   hz_b1[k], hz_b0[k], exp_hz(a, 1'b1), exp_hz(a, 1'b0));
        end
      end
      checks++;
      if (bv_b1 !== exp_bv() || bv_b0 !== exp_bv() || int'(pc_b1) != exp_cnt() || int'(pc_b0) != exp_cnt()) begin
        failures++;
        $display("FAIL rnd_sb cyc=%0d got=bv%h cnt%0d exp=bv%h cnt%0d", cyc, bv_b1, pc_b1, exp_bv(), exp_cnt());
      end
      tick();
    end
    idle();
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    idle();
    flush = 1'b1;
    tick();
    idle();
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_rd = N'(i);
      we = 1'b1; addr_rd = N'(10 + i); data_in = 32'hCAFE0000 + i;
      tick();
    end
    idle();
    addr_rs = {5'd12, 5'd11};
    #2;
    checks++;
    if (pc_b1 !== 6'd3 || rs_b1[31:0] !== 32'hCAFE0001) begin
      failures++; $display("FAIL arst_pre got=cnt=%0d rs=%h exp=3/cafe0001", pc_b1, rs_b1[31:0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bv_b1 !== '0 || bv_b0 !== '0 || pc_b1 !== '0 || pc_b0 !== '0) begin
      failures++; $display("FAIL arst_sb got=bv%h cnt%0d exp=0/0", bv_b1, pc_b1);
    end
    checks++;
    if (rs_b1 !== '0 || rs_b0 !== '0) begin
      failures++; $display("FAIL arst_regs got=%h/%h exp=0", rs_b1, rs_b0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_hazard();
    test_same_cycle();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
